// File: rtl/micro_pkg.sv
// ----------------------------------------------------------------------------
// micro_pkg
// Shared definitions for the micro-sequencer slice:
//   - STATE_W_DEFAULT : default width of a control-unit state number
//   - sel_e           : next-state mode select encodings
// ----------------------------------------------------------------------------
package micro_pkg;

    localparam int STATE_W_DEFAULT = 7;

    typedef enum logic [2:0] {
        SEL_ENC   = 3'd0,   // load decoded state from the instruction encoder
        SEL_FETCH = 3'd1,   // go to the fetch state
        SEL_INC   = 3'd2,   // state + 1
        SEL_JMP   = 3'd3,   // load literal target
        SEL_CJMP  = 3'd4,   // conditional jump, else state + 1
        SEL_WAIT  = 3'd5,   // stall until memory operation completes
        SEL_CALL  = 3'd6,   // push return state, load literal target
        SEL_RET   = 3'd7    // pop return state
    } sel_e;

endpackage

// File: rtl/micro_sequencer_if.sv
// ----------------------------------------------------------------------------
// micro_sequencer_if
// Bundles the sequencer's control inputs and status outputs.
//   master : drives enc_state, cr_addr, sel, cond, inv, moc;
//            observes state, stack_full, stack_empty, err
//   slave  : the sequencer itself (opposite directions)
// ----------------------------------------------------------------------------
interface micro_sequencer_if
    import micro_pkg::*;
#(
    parameter int STATE_W = STATE_W_DEFAULT
);
    logic [STATE_W-1:0] enc_state;
    logic [STATE_W-1:0] cr_addr;
    sel_e               sel;
    logic               cond;
    logic               inv;
    logic               moc;
    logic [STATE_W-1:0] state;
    logic               stack_full;
    logic               stack_empty;
    logic               err;

    modport master (
        output enc_state, cr_addr, sel, cond, inv, moc,
        input  state, stack_full, stack_empty, err
    );

    modport slave (
        input  enc_state, cr_addr, sel, cond, inv, moc,
        output state, stack_full, stack_empty, err
    );
endinterface

// File: rtl/micro_stack.sv
// ----------------------------------------------------------------------------
// micro_stack
// LIFO return stack with a combinational top-of-stack output so a pop
// completes in a single cycle.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset (empties the stack)
//   push  : write din as new top (ignored when full)
//   pop   : discard top entry (ignored when empty)
//   din   : value to push
//   dout  : current top entry (0 when empty)
//   full  : entry count == DEPTH
//   empty : entry count == 0
// ----------------------------------------------------------------------------
module micro_stack #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    if (DEPTH < 2 || DEPTH > 16) begin : g_depth_check
        $error("micro_stack: DEPTH must be between 2 and 16");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] top;

    assign top   = count - CNT_W'(1);
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign dout  = empty ? '0 : mem[top[PTR_W-1:0]];

    // NOTE: storage is deliberately not reset; clearing the count is enough
    // to discard the contents, and it keeps the array a plain register file.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[count[PTR_W-1:0]] <= din;
        end
    end

    // Push has priority; the sequencer never requests both in one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            count <= count - CNT_W'(1);
        end
    end
endmodule

// File: rtl/micro_sequencer.sv
// ----------------------------------------------------------------------------
// micro_sequencer
// Control-unit next-state sequencer with a call/return stack.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : micro_sequencer_if.slave
//           in : enc_state, cr_addr, sel, cond, inv, moc
//           out: state (registered), stack_full, stack_empty, err (sticky)
// ----------------------------------------------------------------------------
module micro_sequencer
    import micro_pkg::*;
#(
    parameter int STATE_W     = STATE_W_DEFAULT,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_STATE = 0,
    parameter int FETCH_STATE = 1
) (
    input logic                clk,
    input logic                reset,
    micro_sequencer_if.slave   bus
);
    localparam logic [STATE_W-1:0] RESET_S = STATE_W'(RESET_STATE);
    localparam logic [STATE_W-1:0] FETCH_S = STATE_W'(FETCH_STATE);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] next_state;
    logic [STATE_W-1:0] inc;
    logic [STATE_W-1:0] stack_top;
    logic               err_q;
    logic               set_err;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;

    // Wraps naturally modulo 2^STATE_W.
    assign inc = state_q + STATE_W'(1);

    micro_stack #(
        .WIDTH (STATE_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (inc),
        .dout  (stack_top),
        .full  (full),
        .empty (empty)
    );

    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        next_state = state_q;
        push       = 1'b0;
        pop        = 1'b0;
        set_err    = 1'b0;
        case (bus.sel)
            SEL_ENC:   next_state = bus.enc_state;
            SEL_FETCH: next_state = FETCH_S;
            SEL_INC:   next_state = inc;
            SEL_JMP:   next_state = bus.cr_addr;
            SEL_CJMP:  next_state = (bus.cond ^ bus.inv) ? bus.cr_addr : inc;
            SEL_WAIT:  next_state = bus.moc ? inc : state_q;
            SEL_CALL: begin
                if (!full) begin
                    push       = 1'b1;
                    next_state = bus.cr_addr;
                end else begin
                    set_err    = 1'b1;
                end
            end
            SEL_RET: begin
                if (!empty) begin
                    pop        = 1'b1;
                    next_state = stack_top;
                end else begin
                    next_state = FETCH_S;
                    set_err    = 1'b1;
                end
            end
            // An unknown select holds state and never touches the stack.
            default:   next_state = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RESET_S;
            err_q   <= 1'b0;
        end else begin
            state_q <= next_state;
            if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!$isunknown(bus.sel))
                else $warning("micro_sequencer: sel is unknown");
        end
    end

    assign bus.state       = state_q;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_micro_sequencer.sv
// ----------------------------------------------------------------------------
// tb_micro_sequencer
// Directed self-checking bench for micro_sequencer (STATE_W=7, depth 4).
// ----------------------------------------------------------------------------
module tb_micro_sequencer;
    import micro_pkg::*;

    localparam int W = 7;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    micro_sequencer_if #(.STATE_W(W)) bus ();

    micro_sequencer #(
        .STATE_W     (W),
        .STACK_DEPTH (4),
        .RESET_STATE (0),
        .FETCH_STATE (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
            else begin
                n_fail++;
                $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            end
    endtask

    // Apply a select, let one rising edge pass, then settle 1 time unit.
    task automatic step(input sel_e s);
        bus.sel = s;
        @(posedge clk);
        #1;
    endtask

    task automatic jump(input int target);
        bus.cr_addr = W'(target);
        step(SEL_JMP);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b0;
        bus.sel       = SEL_ENC;
        bus.enc_state = 7'd5;
        bus.cr_addr   = '0;
        bus.cond      = 1'b0;
        bus.inv       = 1'b0;
        bus.moc       = 1'b0;

        // Reset held across edges
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(bus.state), 0);
        check("rst_empty", 32'(bus.stack_empty), 1);
        check("rst_full",  32'(bus.stack_full), 0);
        check("rst_err",   32'(bus.err), 0);

        // First edge after release performs ENC
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("enc_first_edge", 32'(bus.state), 5);

        // Increment wrap
        jump(126);
        check("jmp_126", 32'(bus.state), 126);
        step(SEL_INC);
        check("inc_127", 32'(bus.state), 127);
        step(SEL_INC);
        check("inc_wrap", 32'(bus.state), 0);
        check("inc_err", 32'(bus.err), 0);

        // Conditional jump
        bus.cr_addr = 7'd40; bus.cond = 1'b1; bus.inv = 1'b0;
        step(SEL_CJMP);
        check("cjmp_taken", 32'(bus.state), 40);
        jump(10);
        bus.cr_addr = 7'd40; bus.cond = 1'b1; bus.inv = 1'b1;
        step(SEL_CJMP);
        check("cjmp_inv_not_taken", 32'(bus.state), 11);
        bus.cond = 1'b0; bus.inv = 1'b1;
        step(SEL_CJMP);
        check("cjmp_inv_taken", 32'(bus.state), 40);
        bus.inv = 1'b0;

        // Wait stall
        jump(12);
        bus.moc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(SEL_WAIT);
            check("wait_hold", 32'(bus.state), 12);
        end
        bus.moc = 1'b1;
        step(SEL_WAIT);
        check("wait_done", 32'(bus.state), 13);
        bus.moc = 1'b0;

        // Nested call/return
        jump(8);
        bus.cr_addr = 7'd20; step(SEL_CALL);
        check("call_20", 32'(bus.state), 20);
        check("call_not_empty", 32'(bus.stack_empty), 0);
        bus.cr_addr = 7'd30; step(SEL_CALL);
        check("call_30", 32'(bus.state), 30);
        step(SEL_RET);
        check("ret_21", 32'(bus.state), 21);
        step(SEL_RET);
        check("ret_9", 32'(bus.state), 9);
        check("ret_empty", 32'(bus.stack_empty), 1);
        check("ret_err", 32'(bus.err), 0);

        // Overflow: four calls fill the stack, the fifth is refused
        bus.cr_addr = 7'd50; step(SEL_CALL);
        bus.cr_addr = 7'd51; step(SEL_CALL);
        bus.cr_addr = 7'd52; step(SEL_CALL);
        bus.cr_addr = 7'd53; step(SEL_CALL);
        check("fill_state", 32'(bus.state), 53);
        check("fill_full", 32'(bus.stack_full), 1);
        check("fill_err", 32'(bus.err), 0);
        bus.cr_addr = 7'd60; step(SEL_CALL);
        check("ovf_hold", 32'(bus.state), 53);
        check("ovf_err", 32'(bus.err), 1);
        check("ovf_full", 32'(bus.stack_full), 1);

        // Drain and underflow
        step(SEL_RET); check("pop_53", 32'(bus.state), 53);
        check("pop_not_full", 32'(bus.stack_full), 0);
        step(SEL_RET); check("pop_52", 32'(bus.state), 52);
        step(SEL_RET); check("pop_51", 32'(bus.state), 51);
        step(SEL_RET); check("pop_10", 32'(bus.state), 10);
        check("drain_empty", 32'(bus.stack_empty), 1);
        step(SEL_RET);
        check("udf_fetch", 32'(bus.state), 1);
        check("udf_err", 32'(bus.err), 1);
        step(SEL_INC);
        check("err_no_block", 32'(bus.state), 2);
        check("err_sticky", 32'(bus.err), 1);

        // Asynchronous reset in the middle of a call/wait sequence
        bus.cr_addr = 7'd70; step(SEL_CALL);
        check("pre_rst_call", 32'(bus.state), 70);
        step(SEL_WAIT);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_state", 32'(bus.state), 0);
        check("async_rst_err", 32'(bus.err), 0);
        check("async_rst_empty", 32'(bus.stack_empty), 1);
        @(negedge clk);
        reset = 1'b1;
        bus.enc_state = 7'd5;
        step(SEL_ENC);
        check("post_rst_enc", 32'(bus.state), 5);
        step(SEL_RET);
        check("post_rst_ret_fetch", 32'(bus.state), 1);
        check("post_rst_ret_err", 32'(bus.err), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter STATE_W, default 7: width of every control-unit state number.
REQ-002 Parameter STACK_DEPTH, default 4: return-stack entry count; legal range is 2 to 16.
REQ-003 Parameter RESET_STATE, default 0: state loaded on reset.
REQ-004 Parameter FETCH_STATE, default 1: state entered on SEL_FETCH and on the return-underflow recovery.
REQ-005 Clk  input  1  clock; all state changes occur on its rising edge.
REQ-006 Reset  input  1  asynchronous, active-low reset.
REQ-007 Enc_state  input  STATE_W  decoded next state from the instruction encoder.
REQ-008 Cr_addr  input  STATE_W  literal jump/call target from the control register.
REQ-009 Sel  input  3  next-state mode select; encodings are defined in REQ-012.
REQ-010 Cond, Inv, Moc  input  1 each  condition flag, condition invert, memory-operation-complete.
REQ-011 State  output  STATE_W  current state, registered; Stack_full, Stack_empty, Err  output  1 each  stack status and sticky error.

Function
REQ-012 Sel encodings: 0 ENC (load Enc_state), 1 FETCH, 2 INC, 3 JMP (load Cr_addr), 4 CJMP, 5 WAIT, 6 CALL, 7 RET.
REQ-013 State shall update only on a rising edge of Clk; a new Sel value is reflected in State exactly one cycle later.
REQ-014 The increment value "State+1" shall wrap modulo 2^STATE_W; the all-ones state increments to 0.
REQ-015 CJMP: if (Cond XOR Inv)=1, load Cr_addr; otherwise load State+1.
REQ-016 WAIT: if Moc=1, load State+1; otherwise hold State. A WAIT may stall for any number of cycles.
REQ-017 CALL with stack not full: push State+1 onto the stack and load Cr_addr, in the same edge.
REQ-018 CALL with stack full: hold State, leave the stack unchanged, and set Err.
REQ-019 RET with stack not empty: pop the top entry into State.
REQ-020 RET with stack empty: load FETCH_STATE and set Err.
REQ-021 The stack is LIFO; at most one push or one pop occurs per cycle.
REQ-022 Stack_full shall be 1 iff the entry count equals STACK_DEPTH.
REQ-023 Stack_empty shall be 1 iff the entry count equals 0.
REQ-024 Stack_full and Stack_empty are combinational decodes of the registered count.
REQ-025 Err is sticky; only Reset clears it. Err does not block sequencing.
REQ-026 Unknown (X) on Sel shall not alter the stack count; simulation shall flag it with a warning.

Reset
REQ-027 While Reset=0: State=RESET_STATE, count=0, Stack_empty=1, Stack_full=0, Err=0.
REQ-028 Reset asserted mid-WAIT or mid-CALL sequence aborts immediately; stack contents are discarded.
REQ-029 After Reset deasserts, the first rising edge performs the normal Sel operation.

Structure
REQ-030 A shared package micro_pkg holds the Sel encoding constants and the default STATE_W.
REQ-031 The return stack shall be a sub-module micro_stack(Clk, Reset, push, pop, din, dout, full, empty), parametrised by width and depth.
REQ-032 micro_stack dout shall present the top entry combinationally, so a pop completes in one cycle.
REQ-033 The next-state multiplexer and the incrementer shall live in micro_sequencer.

Verification
REQ-034 Reset low, Sel=ENC, Enc_state=7'd5 -> State=0 while low. Release, one edge -> State=5.
REQ-035 INC sequence: State=7'd126 -> 127 -> 0 (wrap). Err stays 0.
REQ-036 CJMP with Cr_addr=7'd40:
- Cond=1, Inv=0 -> State=40.
- Cond=1, Inv=1 from State=10 -> State=11.
REQ-037 WAIT at State=12 with Moc=0 for 3 cycles -> State stays 12. Moc=1 -> State=13.
REQ-038 CALL with Cr_addr=7'd20 from State=8, then CALL with Cr_addr=7'd30 from 20, then RET twice:
- State sequence 20, 30, 21, 9.
- Stack_empty=1 at the end.
REQ-039 Overflow/underflow, STACK_DEPTH=4:
- Fifth CALL -> State held, Err=1, Stack_full=1.
- Four RETs then one more RET -> State=FETCH_STATE, Err stays 1 until Reset.
